neighbor_exchange_receiver: RTL
===============================

Name: neighbor_exchange_receiver

Overview:
- Receive-side endpoint of the PPU neighbor halo-exchange protocol.
- Accepts (value, row, column) writes from up to NEIGHBOR_COUNT neighbor PPUs into per-neighbor FIFOs, and drives per-neighbor clear-to-send.
- Drains the FIFOs round-robin, one entry per cycle, into the local output-buffer write port.
- Reports completion once every neighbor has signalled exchange done and all FIFOs are empty.

Parameters:
- TILE_SIZE, 128, tile edge; row and column width RCW = $clog2(TILE_SIZE).
- NEIGHBOR_COUNT, 8, number of neighbor links.
- FIFO_DEPTH, 4, entries per neighbor FIFO; power of two, minimum 2.
- VALUE_WIDTH, 8, width of an exchanged activation value.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- exchange_start  input  1  one-cycle pulse; opens a new exchange round.
- neighbor_input_value  input  [VALUE_WIDTH-1:0] x NEIGHBOR_COUNT  incoming value per link.
- neighbor_input_row  input  [RCW-1:0] x NEIGHBOR_COUNT  destination row.
- neighbor_input_column  input  [RCW-1:0] x NEIGHBOR_COUNT  destination column.
- neighbor_input_write_enable  input  1 x NEIGHBOR_COUNT  write strobe per link.
- neighbor_exchange_done  input  1 x NEIGHBOR_COUNT  sender finished; level or pulse.
- neighbor_cts  output  1 x NEIGHBOR_COUNT  clear-to-send back to each sender.
- out_row  output  RCW  drained row.
- out_column  output  RCW  drained column.
- out_value  output  VALUE_WIDTH  drained value.
- out_source  output  $clog2(NEIGHBOR_COUNT)  link the drained entry came from.
- out_write_enable  output  1  drained entry valid.
- exchange_complete  output  1  one-cycle pulse at end of round.
- busy  output  1  high while in RECEIVE or DRAIN.
- overflow_error  output  1  sticky; write to a full FIFO, or any write while IDLE.

Behaviour:
- Reset: all outputs 0; FIFOs emptied; done flags cleared; round-robin pointer = 0; state = IDLE.
  - Reset asserted mid-round aborts immediately; no exchange_complete pulse is generated.
- States:
  - IDLE -> RECEIVE on exchange_start.
  - RECEIVE -> DRAIN when all done flags are set.
  - DRAIN -> IDLE when all FIFOs are empty and no entry is in the output register; exchange_complete pulses on that transition.
  - exchange_start outside IDLE is ignored.
- Done flags:
  - done[i] is set on any cycle neighbor_exchange_done[i]=1 in RECEIVE or DRAIN.
  - All flags clear on entry to RECEIVE.
  - A write and a done on the same cycle: the write is still accepted.
- Writes:
  - In RECEIVE or DRAIN, neighbor_input_write_enable[i]=1 pushes {value,row,column} into FIFO i at the clock edge.
  - If FIFO i is full, the entry is dropped and overflow_error is set.
  - In IDLE, all writes are dropped and overflow_error is set.
  - overflow_error clears only on reset.
- Clear-to-send:
  - neighbor_cts[i] is registered.
  - It is 1 when state is RECEIVE or DRAIN and FIFO i occupancy after the current edge is <= FIFO_DEPTH-2.
  - The one-entry slack absorbs a sender that writes in the same cycle cts falls.
  - It is 0 once done[i] is set and in IDLE.
- Drain:
  - Each cycle, grant the lowest non-empty FIFO index at or after the pointer, wrapping modulo NEIGHBOR_COUNT.
  - Pop the granted entry into the registered out_* signals with out_write_enable=1 for one cycle; the pointer becomes grant+1 (wraps).
  - If no FIFO is non-empty, out_write_enable=0 and out_row/out_column/out_value hold their previous values.
  - Drain runs in both RECEIVE and DRAIN.
- Simultaneous push and pop on the same FIFO in one cycle is legal; occupancy is unchanged.
- Latency: an entry written at edge k appears on out_* at edge k+1 at the earliest, if its FIFO wins arbitration.
- Throughput: 1 entry per cycle total.
- There is no output backpressure; the downstream buffer accepts every cycle.

Optional Feature:
- Macro: NEIGHBOR_RX_COUNT_EN.
- When defined:
  - Adds output rx_count [15:0], counting accepted (non-dropped) pushes in the current round.
  - Cleared on entry to RECEIVE and on reset; saturates at 16'hFFFF.
  - Holds its value after exchange_complete until the next round.
- When undefined: no port and no counter logic.

Test Plan:
- Basic: reset; exchange_start; neighbor 3 writes (value 8'h5A, row 7, column 9) once; all 8 neighbors assert done -> out_write_enable=1 with out_source=3, row 7, column 9, value 8'h5A one edge after the push; exchange_complete pulses once; busy returns to 0.
- Round-robin: links 0, 2 and 5 each write 2 entries on the same cycles -> drained sources in the order 0,2,5,0,2,5; no stall cycles once the first entries are available.
- Backpressure: FIFO_DEPTH=4; link 1 writes every cycle while links 0 and 2-7 also hold data -> neighbor_cts[1] drops when occupancy reaches 3; no drop when the sender honours cts; overflow_error stays 0.
- Overflow: link 6 writes 5 entries back-to-back, ignoring cts, with arbitration starved by other links -> overflow_error=1; the 5th entry is never output.
- Completion ordering: done from all links arrives while 3 entries are still queued -> exchange_complete only after the 3rd entry is output; a write in IDLE afterward sets overflow_error.
- Reset mid-DRAIN: assert reset with entries pending -> next cycle all outputs 0, no exchange_complete pulse; with NEIGHBOR_RX_COUNT_EN defined, rx_count=0.

Source files
------------

// File: rtl/neighbor_exchange_receiver.sv
`default_nettype none
// ============================================================================
// Module   : neighbor_exchange_receiver
// Brief    : Receive endpoint of the neighbor halo exchange. Per-link FIFOs with
//            registered clear-to-send, round-robin drain into the output buffer.
//            Optional macro NEIGHBOR_RX_COUNT_EN adds the rx_count output.
// Revision : 1.0
// ============================================================================
module neighbor_exchange_receiver #(
   parameter  int TILE_SIZE      = 128,
   parameter  int NEIGHBOR_COUNT = 8,
   parameter  int FIFO_DEPTH     = 4,
   parameter  int VALUE_WIDTH    = 8,
   localparam int RCW            = $clog2(TILE_SIZE),
   localparam int SRC_W          = $clog2(NEIGHBOR_COUNT)
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       exchange_start,
   input  logic [NEIGHBOR_COUNT-1:0][VALUE_WIDTH-1:0] neighbor_input_value,
   input  logic [NEIGHBOR_COUNT-1:0][RCW-1:0]         neighbor_input_row,
   input  logic [NEIGHBOR_COUNT-1:0][RCW-1:0]         neighbor_input_column,
   input  logic [NEIGHBOR_COUNT-1:0]                  neighbor_input_write_enable,
   input  logic [NEIGHBOR_COUNT-1:0]                  neighbor_exchange_done,
   output logic [NEIGHBOR_COUNT-1:0]                  neighbor_cts,
   output logic [RCW-1:0]                             out_row,
   output logic [RCW-1:0]                             out_column,
   output logic [VALUE_WIDTH-1:0]                     out_value,
   output logic [SRC_W-1:0]                           out_source,
   output logic                                       out_write_enable,
   output logic                                       exchange_complete,
   output logic                                       busy,
   output logic                                       overflow_error
`ifdef NEIGHBOR_RX_COUNT_EN
   ,
   output logic [15:0]                                rx_count
`endif
);

   localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w   = c_ptr_w + 1;
   localparam int c_entry_w = VALUE_WIDTH + 2 * RCW;
   localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
   localparam logic [c_cnt_w-1:0] c_cts_limit = c_cnt_w'(FIFO_DEPTH - 2);
   localparam logic [SRC_W-1:0]   c_last_src  = SRC_W'(NEIGHBOR_COUNT - 1);
   localparam logic [SRC_W:0]     c_count_ext = (SRC_W + 1)'(NEIGHBOR_COUNT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   state_t                                   r_state;
   state_t                                   w_state_next;
   logic [NEIGHBOR_COUNT-1:0]                r_done;
   logic [NEIGHBOR_COUNT-1:0]                w_done_next;
   logic [NEIGHBOR_COUNT-1:0]                r_cts;
   logic [NEIGHBOR_COUNT-1:0]                w_cts_next;
   logic [NEIGHBOR_COUNT-1:0]                w_push;
   logic [NEIGHBOR_COUNT-1:0]                w_drop;
   logic [NEIGHBOR_COUNT-1:0]                w_pop;
   logic [NEIGHBOR_COUNT-1:0]                w_nonempty;
   logic [NEIGHBOR_COUNT-1:0]                w_full;
   logic [NEIGHBOR_COUNT-1:0][c_cnt_w-1:0]   w_count;
   logic [NEIGHBOR_COUNT-1:0][c_cnt_w-1:0]   w_count_next;
   logic [NEIGHBOR_COUNT-1:0][c_entry_w-1:0] w_head;
   logic [SRC_W-1:0]                         r_ptr;
   logic [SRC_W-1:0]                         w_ptr_next;
   logic [SRC_W-1:0]                         w_grant;
   logic                                     w_grant_valid;
   logic [SRC_W:0]                           w_idx;
   logic [c_entry_w-1:0]                     w_out_entry;
   logic                                     w_active;
   logic                                     w_enter_receive;
   logic                                     w_all_empty;
   logic                                     w_complete_next;

   logic [RCW-1:0]         r_out_row;
   logic [RCW-1:0]         r_out_column;
   logic [VALUE_WIDTH-1:0] r_out_value;
   logic [SRC_W-1:0]       r_out_source;
   logic                   r_out_we;
   logic                   r_complete;
   logic                   r_busy;
   logic                   r_overflow;

   assign w_active        = (r_state != ST_IDLE);
   assign w_enter_receive = (r_state == ST_IDLE) && exchange_start;
   assign w_all_empty     = ~|w_nonempty;

   generate
      for (genvar i = 0; i < NEIGHBOR_COUNT; i++) begin : g_link
         logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
         logic [c_cnt_w-1:0]   r_wr;
         logic [c_cnt_w-1:0]   r_rd;

         // Pointers carry one extra wrap bit so full and empty are distinguishable.
         assign w_count[i]      = r_wr - r_rd;
         assign w_nonempty[i]   = (w_count[i] != '0);
         assign w_full[i]       = (w_count[i] == c_depth);
         assign w_push[i]       = w_active && neighbor_input_write_enable[i] && !w_full[i];
         assign w_drop[i]       = neighbor_input_write_enable[i] && (!w_active || w_full[i]);
         assign w_pop[i]        = w_grant_valid && (w_grant == SRC_W'(i));
         assign w_head[i]       = r_mem[r_rd[c_ptr_w-1:0]];
         assign w_count_next[i] = w_count[i] + c_cnt_w'(w_push[i]) - c_cnt_w'(w_pop[i]);

         always_ff @(posedge clk) begin
            if (reset) begin
               r_wr <= '0;
               r_rd <= '0;
            end else begin
               if (w_push[i]) r_wr <= r_wr + c_cnt_w'(1);
               if (w_pop[i])  r_rd <= r_rd + c_cnt_w'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (w_push[i]) begin
               r_mem[r_wr[c_ptr_w-1:0]] <= {neighbor_input_value[i],
                                            neighbor_input_row[i],
                                            neighbor_input_column[i]};
            end
         end
      end
   endgenerate

   // Scan from the round-robin pointer upward, wrapping; first non-empty link wins.
   always_comb begin
      w_grant       = '0;
      w_grant_valid = 1'b0;
      w_idx         = '0;
      for (int k = 0; k < NEIGHBOR_COUNT; k++) begin
         w_idx = {1'b0, r_ptr} + (SRC_W + 1)'(k);
         if (w_idx >= c_count_ext) w_idx = w_idx - c_count_ext;
         if (!w_grant_valid && w_active && w_nonempty[w_idx[SRC_W-1:0]]) begin
            w_grant_valid = 1'b1;
            w_grant       = w_idx[SRC_W-1:0];
         end
      end
   end

   assign w_ptr_next  = (w_grant == c_last_src) ? '0 : w_grant + SRC_W'(1);
   assign w_out_entry = w_head[w_grant];

   always_comb begin
      w_done_next = r_done;
      if (w_enter_receive)  w_done_next = '0;
      else if (w_active)    w_done_next = r_done | neighbor_exchange_done;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (exchange_start) w_state_next = ST_RECEIVE;
         ST_RECEIVE: if (&r_done)        w_state_next = ST_DRAIN;
         // A push landing on the exit cycle would be stranded, so it holds DRAIN.
         ST_DRAIN:   if (w_all_empty && !r_out_we && !(|w_push)) w_state_next = ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   assign w_complete_next = (r_state == ST_DRAIN) && (w_state_next == ST_IDLE);

   always_comb begin
      w_cts_next = '0;
      for (int k = 0; k < NEIGHBOR_COUNT; k++) begin
         w_cts_next[k] = (w_state_next != ST_IDLE) && !w_done_next[k] &&
                         (w_count_next[k] <= c_cts_limit);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_done       <= '0;
         r_cts        <= '0;
         r_ptr        <= '0;
         r_out_row    <= '0;
         r_out_column <= '0;
         r_out_value  <= '0;
         r_out_source <= '0;
         r_out_we     <= 1'b0;
         r_complete   <= 1'b0;
         r_busy       <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_done     <= w_done_next;
         r_cts      <= w_cts_next;
         r_busy     <= (w_state_next != ST_IDLE);
         r_complete <= w_complete_next;
         r_overflow <= r_overflow | (|w_drop);
         r_out_we   <= w_grant_valid;
         if (w_grant_valid) begin
            r_ptr        <= w_ptr_next;
            r_out_value  <= w_out_entry[c_entry_w-1 -: VALUE_WIDTH];
            r_out_row    <= w_out_entry[2*RCW-1 -: RCW];
            r_out_column <= w_out_entry[RCW-1:0];
            r_out_source <= w_grant;
         end
      end
   end

`ifdef NEIGHBOR_RX_COUNT_EN
   logic [15:0] r_rx_count;
   logic [16:0] w_rx_sum;

   always_comb begin
      w_rx_sum = {1'b0, r_rx_count};
      for (int k = 0; k < NEIGHBOR_COUNT; k++) begin
         w_rx_sum = w_rx_sum + 17'(w_push[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_enter_receive) r_rx_count <= '0;
      else                          r_rx_count <= w_rx_sum[16] ? 16'hFFFF : w_rx_sum[15:0];
   end

   assign rx_count = r_rx_count;
`endif

   assign neighbor_cts      = r_cts;
   assign out_row           = r_out_row;
   assign out_column        = r_out_column;
   assign out_value         = r_out_value;
   assign out_source        = r_out_source;
   assign out_write_enable  = r_out_we;
   assign exchange_complete = r_complete;
   assign busy              = r_busy;
   assign overflow_error    = r_overflow;

endmodule
`default_nettype wire
